// File: rtl/simon_pkg.sv
// simon_pkg
// Shared types and constants for the Simon sequencer.
//   state_t    : sequencer FSM states
//   LFSR_TAPS  : Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1
package simon_pkg;

    typedef enum logic [3:0] {
        IDLE,
        APPEND,
        SHOW_ON,
        SHOW_OFF,
        WAIT_PRESS,
        WAIT_REL,
        CHECK,
        LOSE,
        LOST,
        WON
    } state_t;

    // Right-shifting Galois form: tap k maps to bit k-1 of the mask.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/simon_lfsr.sv
// simon_lfsr
// Free-running 16-bit Galois LFSR used as the colour source.
// Ports:
//   clk      in   system clock
//   reset_n  in   synchronous active-low reset, loads SEED
//   value    out  current LFSR state, advances every clock
module simon_lfsr
    import simon_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [15:0] value
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            value <= SEED;
        end else begin
            value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/simon_sequencer.sv
// simon_sequencer
// Simon-style memory game controller: grows a random colour sequence one
// entry per round, plays it back with programmable on/off timing, then
// checks the player's debounced presses against it.
// Optional macro SIMON_SPEEDUP_EN: shortens the show time by 1/8 of
// ON_TICKS per completed round, floored at 1/4 of ON_TICKS.
// Ports:
//   clk          in   system clock
//   reset_n      in   synchronous active-low reset
//   start        in   pulse: new game (IDLE/LOST/WON only)
//   replay       in   pulse: re-show current sequence (WAIT_PRESS only)
//   press        in   one-cycle debounced press pulses, bit i = channel i
//   released     in   one-cycle debounced release pulses, bit i = channel i
//   show_valid   out  colour/tone driver enable
//   show_ch      out  channel to light/sound while show_valid
//   player_turn  out  high while waiting for the player
//   score        out  rounds completed this game
//   lose         out  one-cycle pulse on a wrong press
//   won          out  level, all MAX_LEN rounds completed
//
// state      | meaning
// IDLE       | after reset, waiting for start
// APPEND     | add one random entry to the sequence
// SHOW_ON    | colour idx lit for the on time
// SHOW_OFF   | gap after each shown colour
// WAIT_PRESS | waiting for the player's next press
// WAIT_REL   | pressed colour echoed until its release
// CHECK      | compare latched press with sequence entry idx
// LOSE       | one-cycle lose pulse
// LOST       | game over, score held
// WON        | all rounds done, won held
module simon_sequencer
    import simon_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          MAX_LEN   = 32,
    parameter int          ON_TICKS  = 75_000_000,
    parameter int          OFF_TICKS = 25_000_000,
    parameter int          TICK_W    = 32,
    parameter logic [15:0] SEED      = 16'hACE1,
    localparam int         CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int         LEN_W     = $clog2(MAX_LEN) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              replay,
    input  logic [NUM_CH-1:0] press,
    input  logic [NUM_CH-1:0] released,
    output logic              show_valid,
    output logic [CH_W-1:0]   show_ch,
    output logic              player_turn,
    output logic [LEN_W-1:0]  score,
    output logic              lose,
    output logic              won
);

    localparam int               IDX_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] ONE_L    = LEN_W'(1);
    localparam logic [TICK_W-1:0] ONE_T   = TICK_W'(1);
    localparam logic [TICK_W-1:0] OFF_LOAD = TICK_W'(OFF_TICKS);

    state_t             state;
    logic [LEN_W-1:0]   length;
    logic [LEN_W-1:0]   idx;
    logic [TICK_W-1:0]  timer;
    logic [CH_W-1:0]    latched;
    logic [CH_W-1:0]    seq_buf [MAX_LEN];

    logic [15:0]        lfsr_val;
    logic [CH_W-1:0]    new_entry;
    logic [CH_W-1:0]    press_idx;
    logic               press_one;
    logic               press_many;
    logic [LEN_W-1:0]   idx_inc;
    logic [LEN_W-1:0]   last_idx;
    logic [TICK_W-1:0]  on_load;

    simon_lfsr #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .value   (lfsr_val)
    );

    assign new_entry  = CH_W'(lfsr_val % 16'(NUM_CH));
    assign press_one  = $onehot(press);
    assign press_many = (press != '0) && !press_one;
    assign idx_inc    = idx + ONE_L;
    assign last_idx   = length - ONE_L;

    always_comb begin
        press_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (press[i]) press_idx = CH_W'(i);
        end
    end

`ifdef SIMON_SPEEDUP_EN
    logic [31:0] score_ext;
    logic [31:0] speed_steps;

    always_comb begin
        score_ext   = 32'(score);
        speed_steps = (score_ext > 32'd6) ? 32'd6 : score_ext;
        on_load     = TICK_W'(32'(ON_TICKS) - 32'(ON_TICKS / 8) * speed_steps);
    end
`else
    assign on_load = TICK_W'(ON_TICKS);
`endif

    // Contents are don't-care after reset, so the buffer carries no reset.
    always_ff @(posedge clk) begin
        if (state == APPEND) begin
            seq_buf[length[IDX_W-1:0]] <= new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            length      <= '0;
            idx         <= '0;
            timer       <= '0;
            latched     <= '0;
            show_valid  <= 1'b0;
            show_ch     <= '0;
            player_turn <= 1'b0;
            score       <= '0;
            lose        <= 1'b0;
            won         <= 1'b0;
        end else begin
            lose <= 1'b0;
            case (state)
                IDLE, LOST, WON: begin
                    if (start) begin
                        state  <= APPEND;
                        score  <= '0;
                        length <= '0;
                        won    <= 1'b0;
                    end
                end
                APPEND: begin
                    length     <= length + ONE_L;
                    idx        <= '0;
                    timer      <= on_load;
                    state      <= SHOW_ON;
                    show_valid <= 1'b1;
                    // Entry 0 of a fresh game is written on this same edge.
                    show_ch    <= (length == '0) ? new_entry : seq_buf[0];
                end
                SHOW_ON: begin
                    if (timer == ONE_T) begin
                        timer      <= OFF_LOAD;
                        state      <= SHOW_OFF;
                        show_valid <= 1'b0;
                        show_ch    <= '0;
                    end else begin
                        timer <= timer - ONE_T;
                    end
                end
                SHOW_OFF: begin
                    if (timer == ONE_T) begin
                        if (idx == last_idx) begin
                            idx         <= '0;
                            state       <= WAIT_PRESS;
                            player_turn <= 1'b1;
                        end else begin
                            idx        <= idx_inc;
                            timer      <= on_load;
                            state      <= SHOW_ON;
                            show_valid <= 1'b1;
                            show_ch    <= seq_buf[idx_inc[IDX_W-1:0]];
                        end
                    end else begin
                        timer <= timer - ONE_T;
                    end
                end
                WAIT_PRESS: begin
                    if (press_many) begin
                        state       <= LOSE;
                        lose        <= 1'b1;
                        player_turn <= 1'b0;
                    end else if (press_one) begin
                        latched    <= press_idx;
                        show_valid <= 1'b1;
                        show_ch    <= press_idx;
                        state      <= WAIT_REL;
                    end else if (replay) begin
                        idx         <= '0;
                        timer       <= on_load;
                        show_valid  <= 1'b1;
                        show_ch     <= seq_buf[0];
                        player_turn <= 1'b0;
                        state       <= SHOW_ON;
                    end
                end
                WAIT_REL: begin
                    if (released[latched]) begin
                        state       <= CHECK;
                        show_valid  <= 1'b0;
                        show_ch     <= '0;
                        player_turn <= 1'b0;
                    end
                end
                CHECK: begin
                    if (latched != seq_buf[idx[IDX_W-1:0]]) begin
                        state <= LOSE;
                        lose  <= 1'b1;
                    end else if (idx != last_idx) begin
                        idx         <= idx_inc;
                        state       <= WAIT_PRESS;
                        player_turn <= 1'b1;
                    end else begin
                        score <= score + ONE_L;
                        if (length == LEN_W'(MAX_LEN)) begin
                            state <= WON;
                            won   <= 1'b1;
                        end else begin
                            state <= APPEND;
                        end
                    end
                end
                LOSE: begin
                    state <= LOST;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
